ita_activation_feeder: RTL and testbench

Streaming front/back end for the activation unit: accepts a job of `len` requantized vectors on a valid/ready input, drives the activation unit's issue-side controls (`calc_en`, `calc_en_q`, `activation`, `activation_q2`, `data`), and captures the fixed-latency results into an output FIFO with valid/ready and a last flag. A credit scheme ensures a result never arrives without a free FIFO entry, so the activation pipeline (which has no stall) is never overrun. The block sits between the requantized output stream and the activation unit.

---
 rtl/ita_activation_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_ita_activation_feeder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_activation_feeder.sv
// Activation feeder: issues requantized vectors into the fixed-latency activation unit and collects results in order.
// Issue-to-capture LATENCY cycles, +1 to out_valid_o; in_ready_o is credit-gated so the stall-free pipeline never overruns the FIFO.

package ita_package;
  localparam int unsigned N  = 16;
  localparam int unsigned WI = 8;
  typedef logic [N-1:0][WI-1:0] requant_oup_t;
  typedef enum logic [1:0] {Identity = 2'd0, Gelu = 2'd1, Relu = 2'd2} activation_e;
endpackage

// Generic FIFO: registered pointers, show-ahead read data.
// Push and pop may coincide; caller guarantees no push on full and no pop on empty.
module ita_feeder_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an empty count hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

module ita_activation_feeder
  import ita_package::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  activation_e  activation_cfg_i,
  input  logic [15:0]  len_i,
  output logic         busy_o,
  output logic         done_o,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  requant_oup_t in_data_i,
  output logic         act_calc_en_o,
  output logic         act_calc_en_q_o,
  output activation_e  act_activation_o,
  output activation_e  act_activation_q2_o,
  output requant_oup_t act_data_o,
  input  requant_oup_t act_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output requant_oup_t out_data_o,
  output logic         out_last_o
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned DW = $bits(requant_oup_t);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  activation_e        cfg_q;
  logic [15:0]        len_q, issued_q, pushed_q;
  logic [LATENCY-1:0] infl_q;
  logic               calc_q, done_q, done_d;
  logic               start_acc, issue, push, pop, push_last, head_last, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [IW-1:0]      inflight;
  logic [OW-1:0]      occupied;
  logic               has_credit;
  logic [DW:0]        push_word, pop_word;

  // Credits cover every issued-but-unpopped result, so a capture always finds a free slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(infl_q[i]);
  end

  assign occupied   = OW'(fifo_count) + OW'(inflight);
  assign has_credit = (occupied < OW'(FIFO_DEPTH));

  assign start_acc  = (state_q == IDLE) && start_i;
  assign in_ready_o = (state_q == RUN) && (issued_q < len_q) && has_credit;
  assign issue      = in_valid_i && in_ready_o;
  assign push       = infl_q[LATENCY-1];
  assign push_last  = (pushed_q == len_q - 16'd1);
  assign pop        = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == 16'd0) done_d = 1'b1;
          else                state_d = RUN;
        end
      end
      RUN: begin
        if (issue && (issued_q == len_q - 16'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      calc_q   <= 1'b0;
      infl_q   <= '0;
      cfg_q    <= Identity;
      len_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      calc_q  <= issue;
      infl_q  <= (infl_q << 1) | LATENCY'(issue);
      if (start_acc) begin
        cfg_q    <= activation_cfg_i;
        len_q    <= len_i;
        issued_q <= '0;
        pushed_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 16'd1;
        if (push)  pushed_q <= pushed_q + 16'd1;
      end
    end
  end

  assign push_word = {push_last, act_data_i};

  ita_feeder_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push),
    .push_dat (push_word),
    .pop      (pop),
    .pop_dat  (pop_word),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign head_last  = pop_word[DW];
  assign out_valid_o = !fifo_empty;
  assign out_last_o  = !fifo_empty && head_last;
  assign out_data_o  = requant_oup_t'(pop_word[DW-1:0]);

  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_q;
  assign act_calc_en_o       = issue;
  assign act_calc_en_q_o     = calc_q;
  assign act_data_o          = issue ? in_data_i : '0;
  assign act_activation_o    = busy_o ? cfg_q : Identity;
  assign act_activation_q2_o = busy_o ? cfg_q : Identity;

endmodule

// File: tb/tb_ita_activation_feeder.sv
// Bench for ita_activation_feeder: stand-in activation pipeline, scoreboard of issued vectors, per-scenario tasks.
module tb_ita_activation_feeder;
  import ita_package::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  activation_e  cfg = Identity;
  logic [15:0]  len = '0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  requant_oup_t in_data = '0;
  logic         busy, done, in_ready, act_en, act_en_q, out_valid, out_last;
  activation_e  act_act, act_act_q2;
  requant_oup_t act_dout, act_din, out_data;

  ita_activation_feeder #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .activation_cfg_i(cfg), .len_i(len),
    .busy_o(busy), .done_o(done), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .act_calc_en_o(act_en), .act_calc_en_q_o(act_en_q), .act_activation_o(act_act),
    .act_activation_q2_o(act_act_q2), .act_data_o(act_dout), .act_data_i(act_din),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in activation unit: Relu clamps negative lanes, Gelu is replaced by a lane XOR.
  function automatic requant_oup_t act_fn(activation_e m, requant_oup_t v);
    requant_oup_t r;
    r = v;
    for (int l = 0; l < N; l++) begin
      if (m == Relu && v[l][WI-1]) r[l] = '0;
      if (m == Gelu) r[l] = v[l] ^ WI'('h5A);
    end
    return r;
  endfunction

  requant_oup_t pipe_d [LAT];
  activation_e  pipe_m [LAT];
  always @(posedge clk) begin
    pipe_d[0] <= act_dout;
    pipe_m[0] <= act_act;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end
  assign act_din = act_fn(pipe_m[LAT-1], pipe_d[LAT-1]);

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation logs and running protocol-violation counters.
  requant_oup_t stim[$], iss_log[$], pop_log[$];
  int           iss_cyc[$], pop_cyc[$], done_cyc[$];
  bit           pop_last[$];
  int           busy_cnt, en_err, dat_err, enq_err, mode_err, db_err, valid_err, occ_err;
  int           model_cnt;
  bit           hist [64];
  bit           prev_en, m_hs, m_push, m_pop;
  activation_e  job_cfg = Identity;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt = 0;
      prev_en   = 1'b0;
      for (int i = 0; i < 64; i++) hist[i] = 1'b0;
    end else begin
      m_hs   = in_valid && in_ready;
      m_push = hist[(cyc + 64 - LAT) % 64];
      m_pop  = out_valid && out_ready;
      if (m_hs) begin iss_log.push_back(in_data); iss_cyc.push_back(cyc); end
      if (m_pop) begin pop_log.push_back(out_data); pop_last.push_back(out_last); pop_cyc.push_back(cyc); end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      if (act_en !== m_hs) en_err++;
      if (act_dout !== (m_hs ? in_data : requant_oup_t'('0))) dat_err++;
      if (act_en_q !== prev_en) enq_err++;
      prev_en = act_en;
      if (busy ? (act_act !== job_cfg || act_act_q2 !== job_cfg)
               : (act_act !== Identity || act_act_q2 !== Identity)) mode_err++;
      if (done && busy) db_err++;
      if (out_valid !== (model_cnt > 0)) valid_err++;
      if (m_push && model_cnt >= DEPTH) occ_err++;
      if (m_pop && model_cnt == 0) occ_err++;
      model_cnt = model_cnt + int'(m_push) - int'(m_pop);
      hist[cyc % 64] = m_hs;
    end
  end

  task automatic clear_logs();
    iss_log.delete(); iss_cyc.delete(); pop_log.delete(); pop_last.delete();
    pop_cyc.delete(); done_cyc.delete(); busy_cnt = 0;
  endtask

  task automatic start_job(input activation_e m, input int l, output int s);
    @(posedge clk); #1;
    start = 1'b1; cfg = m; len = 16'(l); job_cfg = m; s = cyc;
    @(posedge clk); #1;
    start = 1'b0; cfg = activation_e'($urandom_range(0, 2)); len = 16'($urandom);
  endtask

  task automatic feed(input int n, input int pct, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && ok) begin
        in_valid = (int'($urandom_range(1, 100)) <= pct);
        in_data  = stim[i];
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        guard++;
        if (guard > 3000) ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input int budget, output int dc, output bit ok);
    ok = 1'b0; dc = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; dc = cyc; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++; if (act_en !== 1'b0) begin n_fail++; $display("FAIL reset_calc_en: got %b want 0", act_en); end
    n_chk++; if (act_en_q !== 1'b0) begin n_fail++; $display("FAIL reset_calc_en_q: got %b want 0", act_en_q); end
    n_chk++; if (act_act !== Identity) begin n_fail++; $display("FAIL reset_activation: got %0d want 0", act_act); end
    n_chk++; if (act_act_q2 !== Identity) begin n_fail++; $display("FAIL reset_activation_q2: got %0d want 0", act_act_q2); end
    n_chk++; if (act_dout !== '0) begin n_fail++; $display("FAIL reset_act_data: got %h want 0", act_dout); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b in_ready=%b out_valid=%b want 0/0/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_identity_b2b();
    int s, dc, t, pc;
    bit ok, ok2;
    ready_mode = 1;
    clear_logs();
    stim.delete();
    for (int i = 1; i <= 3; i++) stim.push_back({N{WI'(i)}});
    start_job(Identity, 3, s);
    feed(3, 100, ok);
    wait_done(100, dc, ok2);
    t = (iss_cyc.size() > 0) ? iss_cyc[0] : -100;
    n_chk++; if (!(ok && ok2)) begin n_fail++; $display("FAIL b2b_timeout: got feed=%b done=%b want 1/1", ok, ok2); end
    n_chk++; if (t !== s + 1) begin n_fail++; $display("FAIL b2b_first_issue: got cycle %0d want %0d", t, s + 1); end
    for (int i = 0; i < 3; i++) begin
      pc = (i < iss_cyc.size()) ? iss_cyc[i] : -1;
      n_chk++; if (pc !== t + i) begin n_fail++; $display("FAIL b2b_issue_cycle[%0d]: got %0d want %0d", i, pc, t + i); end
      pc = (i < pop_cyc.size()) ? pop_cyc[i] : -1;
      n_chk++; if (pc !== t + LAT + 1 + i) begin n_fail++; $display("FAIL b2b_out_cycle[%0d]: got %0d want %0d", i, pc, t + LAT + 1 + i); end
    end
    n_chk++; if (pop_log.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 3; i++) begin
      n_chk++; if (pop_log[i] !== stim[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, pop_log[i], stim[i]); end
      n_chk++; if (pop_last[i] !== (i == 2)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b want %b", i, pop_last[i], i == 2); end
    end
    n_chk++; if (dc !== t + 8) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", dc, t + 8); end
    n_chk++; if (en_err !== 0 || dat_err !== 0) begin n_fail++; $display("FAIL b2b_issue_side: got en_err=%0d dat_err=%0d want 0", en_err, dat_err); end
  endtask

  task automatic test_len_zero();
    int s;
    clear_logs();
    start_job(Identity, 0, s);
    repeat (6) @(posedge clk); #1;
    n_chk++; if (done_cyc.size() !== 1) begin n_fail++; $display("FAIL len0_done_count: got %0d want 1", done_cyc.size()); end
    n_chk++; if (done_cyc.size() > 0 && done_cyc[0] !== s + 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d want %0d", done_cyc[0], s + 1); end
    n_chk++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL len0_busy: got %0d busy cycles want 0", busy_cnt); end
    n_chk++; if (iss_log.size() !== 0 || en_err !== 0) begin n_fail++; $display("FAIL len0_calc_en: got issues=%0d en_err=%0d want 0", iss_log.size(), en_err); end
  endtask

  task automatic test_relu_backpressure();
    int s, dc, n1;
    bit ok, ok2, r1;
    requant_oup_t v;
    ready_mode = 0;
    clear_logs();
    stim.delete();
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < N; l++) v[l] = (l % 2 == 0) ? WI'(-(5 + i)) : WI'(7 + i);
      stim.push_back(v);
    end
    start_job(Relu, 16, s);
    fork
      feed(16, 100, ok);
      begin
        repeat (30) @(posedge clk); #1;
        n1 = iss_log.size();
        r1 = in_ready;
        ready_mode = 1;
      end
    join
    wait_done(300, dc, ok2);
    n_chk++; if (n1 !== DEPTH) begin n_fail++; $display("FAIL relu_stall_issues: got %0d want %0d", n1, DEPTH); end
    n_chk++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL relu_stall_ready: got %b want 0", r1); end
    n_chk++; if (!(ok && ok2)) begin n_fail++; $display("FAIL relu_timeout: got feed=%b done=%b want 1/1", ok, ok2); end
    n_chk++; if (pop_log.size() !== 16) begin n_fail++; $display("FAIL relu_count: got %0d want 16", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 16; i++) begin
      n_chk++; if (pop_log[i] !== act_fn(Relu, stim[i])) begin n_fail++; $display("FAIL relu_data[%0d]: got %h want %h", i, pop_log[i], act_fn(Relu, stim[i])); end
      n_chk++; if (pop_last[i] !== (i == 15)) begin n_fail++; $display("FAIL relu_last[%0d]: got %b want %b", i, pop_last[i], i == 15); end
    end
    n_chk++; if (occ_err !== 0 || valid_err !== 0) begin n_fail++; $display("FAIL relu_fifo_protocol: got occ_err=%0d valid_err=%0d want 0", occ_err, valid_err); end
  endtask

  task automatic test_random_gelu();
    int s, dc;
    bit ok, ok2;
    requant_oup_t v;
    ready_mode = 2;
    clear_logs();
    stim.delete();
    for (int i = 0; i < 100; i++) begin
      for (int l = 0; l < N; l++) v[l] = WI'($urandom);
      stim.push_back(v);
    end
    start_job(Gelu, 100, s);
    feed(100, 50, ok);
    wait_done(3000, dc, ok2);
    n_chk++; if (!(ok && ok2)) begin n_fail++; $display("FAIL gelu_timeout: got feed=%b done=%b want 1/1", ok, ok2); end
    n_chk++; if (pop_log.size() !== 100) begin n_fail++; $display("FAIL gelu_count: got %0d want 100", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 100; i++) begin
      n_chk++; if (pop_log[i] !== act_fn(Gelu, stim[i])) begin n_fail++; $display("FAIL gelu_data[%0d]: got %h want %h", i, pop_log[i], act_fn(Gelu, stim[i])); end
      n_chk++; if (pop_last[i] !== (i == 99)) begin n_fail++; $display("FAIL gelu_last[%0d]: got %b want %b", i, pop_last[i], i == 99); end
    end
    n_chk++; if (enq_err !== 0) begin n_fail++; $display("FAIL gelu_calc_en_q: got %0d bad cycles want 0", enq_err); end
    n_chk++; if (mode_err !== 0) begin n_fail++; $display("FAIL gelu_mode: got %0d bad cycles want 0", mode_err); end
    n_chk++; if (occ_err !== 0 || valid_err !== 0 || db_err !== 0) begin
      n_fail++; $display("FAIL gelu_protocol: got occ=%0d valid=%0d done_busy=%0d want 0", occ_err, valid_err, db_err);
    end
  endtask

  task automatic test_start_ignored();
    int s, dc;
    bit ok, ok2;
    requant_oup_t v;
    ready_mode = 2;
    clear_logs();
    stim.delete();
    for (int i = 0; i < 10; i++) begin
      for (int l = 0; l < N; l++) v[l] = WI'($urandom);
      stim.push_back(v);
    end
    start_job(Identity, 10, s);
    fork
      feed(10, 60, ok);
      begin
        repeat (4) @(posedge clk); #1;
        start = 1'b1; len = 16'd5; cfg = Relu;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(1000, dc, ok2);
    n_chk++; if (!(ok && ok2)) begin n_fail++; $display("FAIL restart_timeout: got feed=%b done=%b want 1/1", ok, ok2); end
    n_chk++; if (pop_log.size() !== 10) begin n_fail++; $display("FAIL restart_count: got %0d want 10", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 10; i++) begin
      n_chk++; if (pop_log[i] !== stim[i]) begin n_fail++; $display("FAIL restart_data[%0d]: got %h want %h", i, pop_log[i], stim[i]); end
      n_chk++; if (pop_last[i] !== (i == 9)) begin n_fail++; $display("FAIL restart_last[%0d]: got %b want %b", i, pop_last[i], i == 9); end
    end
    n_chk++; if (done_cyc.size() !== 1 || mode_err !== 0) begin n_fail++; $display("FAIL restart_done_mode: got dones=%0d mode_err=%0d want 1/0", done_cyc.size(), mode_err); end
  endtask

  task automatic test_reset_midjob();
    int s, dc, g;
    bit ok, ok2;
    requant_oup_t v;
    ready_mode = 0;
    clear_logs();
    stim.delete();
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < N; l++) v[l] = WI'($urandom);
      stim.push_back(v);
    end
    start_job(Identity, 16, s);
    feed(7, 100, ok);
    g = 0;
    while (model_cnt != 4 && g < 50) begin @(posedge clk); #1; g++; end
    n_chk++; if (!ok || model_cnt !== 4 || iss_log.size() - model_cnt !== 3) begin
      n_fail++; $display("FAIL rst_setup: got fifo=%0d inflight=%0d want 4/3", model_cnt, iss_log.size() - model_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_ctrl: got busy=%b done=%b in_ready=%b want 0/0/0", busy, done, in_ready);
    end
    n_chk++; if (act_en !== 1'b0 || act_en_q !== 1'b0 || act_dout !== '0) begin
      n_fail++; $display("FAIL rst_async_issue: got en=%b en_q=%b data=%h want 0", act_en, act_en_q, act_dout);
    end
    n_chk++; if (act_act !== Identity || act_act_q2 !== Identity) begin
      n_fail++; $display("FAIL rst_async_mode: got %0d/%0d want 0/0", act_act, act_act_q2);
    end
    n_chk++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_out: got valid=%b last=%b want 0/0", out_valid, out_last);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    clear_logs();
    repeat (10) @(posedge clk); #1;
    n_chk++; if (pop_log.size() !== 0 || valid_err !== 0) begin
      n_fail++; $display("FAIL rst_stale_out: got pops=%0d valid_err=%0d want 0/0", pop_log.size(), valid_err);
    end
    stim.delete();
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < N; l++) v[l] = WI'($urandom);
      stim.push_back(v);
    end
    start_job(Relu, 3, s);
    feed(3, 100, ok);
    wait_done(100, dc, ok2);
    n_chk++; if (!(ok && ok2) || pop_log.size() !== 3) begin
      n_fail++; $display("FAIL rst_rerun: got feed=%b done=%b pops=%0d want 1/1/3", ok, ok2, pop_log.size());
    end
    for (int i = 0; i < pop_log.size() && i < 3; i++) begin
      n_chk++; if (pop_log[i] !== act_fn(Relu, stim[i]) || pop_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL rst_rerun_out[%0d]: got %h last=%b want %h last=%b", i, pop_log[i], pop_last[i], act_fn(Relu, stim[i]), i == 2);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_identity_b2b();
    test_len_zero();
    test_relu_backpressure();
    test_random_gelu();
    test_start_ignored();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
